wash_phase_timer: RTL
=====================

# wash_phase_timer

Phase timer that answers the washing-machine controller: it watches the controller's 3-bit `state` and returns the completion events the controller waits on: `sig_Full`, `sig_Temperature`, `sig_Completed` and `sig_Time_Out`. It also reports the current `mode` group. It sits beside the controller inside the microcontroller top. Each timed phase is modelled as a programmable cycle count, and a watchdog flags a controller that idles in READY or stalls after a phase has finished.

## Interface
- `FILL_CYCLES`, 8, cycles spent in FILL_WATER before `sig_Full`
- `HEAT_CYCLES`, 12, cycles spent in HEAT_WATER before `sig_Temperature`
- `WASH_CYCLES`, 20, cycles spent in WASH before `sig_Completed`
- `RINSE_CYCLES`, 16, cycles spent in RINSE before `sig_Completed`
- `SPIN_CYCLES`, 10, cycles spent in SPIN before `sig_Completed`
- `TIMEOUT_CYCLES`, 64, watchdog limit for READY idle and for a post-done stall
- `CNT_W`, 8, counter width; every limit satisfies 1 ≤ limit ≤ 2^CNT_W
- `clock` input 1: single clock, rising edge
- `reset_n` input 1: asynchronous, active-low reset
- `state` input 3: controller state; 0 IDLE, 1 READY, 2 FILL_WATER, 3 HEAT_WATER, 4 WASH, 5 RINSE, 6 SPIN, 7 FAULT
- `sig_Full` output 1: one-cycle pulse, fill phase complete
- `sig_Temperature` output 1: one-cycle pulse, heat phase complete
- `sig_Completed` output 1: one-cycle pulse, wash, rinse or spin complete
- `sig_Time_Out` output 1: one-cycle pulse from the watchdog
- `mode` output 2: 00 idle/ready/fault, 01 fill/heat, 10 wash/rinse, 11 spin

## Operation
- **Registers:** `prev_state` (3 bits), `cnt` (CNT_W bits), the timer FSM and the four registered event outputs.
- **Timer FSM states:** T_IDLE, T_RUN, T_DONE, T_HOLD.
- **Change-detect edge:** any edge where `state != prev_state`.
  - `prev_state <= state`, `cnt <= 0`, all pulses 0.
  - `mode` is updated from the new state.
  - The FSM goes to T_RUN for states 1–6 and to T_IDLE for states 0 and 7.
  - A state change takes priority over every other event on the same edge.
- **Phase limit (`LIMIT`):**
  - States 2–6 use the corresponding `*_CYCLES` parameter.
  - READY (1) uses `TIMEOUT_CYCLES`, and its event is `sig_Time_Out`.
- **T_RUN, `cnt == LIMIT-1`:** assert the state's event output for the next cycle, `cnt <= 0`, go to T_DONE.
- **T_RUN, `cnt < LIMIT-1`:** `cnt <= cnt+1`.
- **T_DONE (states 2–6):**
  - Pulses drop on the first T_DONE edge.
  - `cnt` increments each edge.
  - At `cnt == TIMEOUT_CYCLES-1` assert `sig_Time_Out` for one cycle and go to T_HOLD.
  - READY goes straight from its timeout to T_HOLD and does not use T_DONE.
- **T_HOLD:** no further pulses; `cnt` is frozen until a state change.
- **T_IDLE:** counter held at 0, all pulses 0.
- **FAULT (7):** behaves as T_IDLE; entering FAULT suppresses any pending pulse.
- **Counter:** only ever compared against `LIMIT-1` and `TIMEOUT_CYCLES-1`, so it never wraps.

## Timing
- **Reset (`reset_n` low):** immediately and asynchronously drives
  - `sig_Full = sig_Temperature = sig_Completed = sig_Time_Out = 0`
  - `mode = 00`
  - `prev_state = 0`, `cnt = 0`, FSM = T_IDLE
- **Reset release:** if `state != 0`, the first edge after release is a change-detect edge and the phase restarts from 0.
- **Phase latency:** numbering the change-detect edge as edge 0, the event pulse is high for exactly one cycle following edge LIMIT.
- **Watchdog latency (states 2–6):** `sig_Time_Out` rises TIMEOUT_CYCLES edges after the event pulse rises.
- **`mode`:** registered; valid the cycle after the change-detect edge.
- **Abandoned phase:** a state change on the edge where a pulse would assert cancels the pulse.
- **Simultaneous events:** at most one output pulse can be high in any cycle.

## Test plan
- **Basic fill:** reset, then `state=2` with FILL_CYCLES=8 → `sig_Full` high for exactly 1 cycle after edge 8; `mode=01` from the cycle after edge 0; no other pulses.
- **Phase sequence:** `state` 3, held until its pulse, then 4 → `sig_Temperature` 12 edges after entering heat, then `sig_Completed` 20 edges after entering wash; `mode` goes 01 then 10.
- **Abandoned phase:** `state=2` for 5 edges, then `state=3` → no `sig_Full`; `sig_Temperature` 12 edges after entering heat.
- **Watchdog:**
  - `state=1` held for 200 cycles → a single `sig_Time_Out` after edge 64, no repeat.
  - `state=6` held → `sig_Completed` after edge 10, `sig_Time_Out` 64 edges later, then silence.
- **Fault:** `state=5` for 10 edges, then `state=7` → no `sig_Completed`; `mode=00`; all outputs 0 while FAULT persists.
- **Reset mid-phase:** `reset_n` low for 3 cycles during wash at `cnt=7`, with `state=4` held → outputs 0 asynchronously; after release, `sig_Completed` 20 edges after the first post-reset edge.

Source files
------------

// File: rtl/wash_phase_timer.sv
`default_nettype none
// ============================================================================
// Module : wash_phase_timer
// Brief  : Phase timer for the washing-machine controller; emits phase-done
//          pulses and a watchdog timeout for READY idle or post-done stalls.
// Rev    : 1.0  initial release
// ============================================================================
module wash_phase_timer #(
  parameter int FILL_CYCLES    = 8,
  parameter int HEAT_CYCLES    = 12,
  parameter int WASH_CYCLES    = 20,
  parameter int RINSE_CYCLES   = 16,
  parameter int SPIN_CYCLES    = 10,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [2:0] state,
  output logic       sig_Full,
  output logic       sig_Temperature,
  output logic       sig_Completed,
  output logic       sig_Time_Out,
  output logic [1:0] mode
);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_ready = 3'd1;
  localparam logic [2:0] c_st_fill  = 3'd2;
  localparam logic [2:0] c_st_heat  = 3'd3;
  localparam logic [2:0] c_st_wash  = 3'd4;
  localparam logic [2:0] c_st_rinse = 3'd5;
  localparam logic [2:0] c_st_spin  = 3'd6;
  localparam logic [2:0] c_st_fault = 3'd7;

  // Terminal counts are stored as LIMIT-1 so a limit of 2^CNT_W still fits.
  localparam logic [CNT_W-1:0] c_fill_last  = CNT_W'(FILL_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_heat_last  = CNT_W'(HEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_wash_last  = CNT_W'(WASH_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_rinse_last = CNT_W'(RINSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_spin_last  = CNT_W'(SPIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_tout_last  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_RUN  = 2'd1,
    T_DONE = 2'd2,
    T_HOLD = 2'd3
  } timer_state_t;

  timer_state_t     r_tstate, w_tstate_nxt;
  logic [2:0]       r_prev_state, w_prev_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] w_limit_last;
  logic [1:0]       r_mode, w_mode_nxt;
  logic             r_full, w_full_nxt;
  logic             r_temp, w_temp_nxt;
  logic             r_comp, w_comp_nxt;
  logic             r_tout, w_tout_nxt;

  function automatic logic [1:0] mode_of(input logic [2:0] s);
    case (s)
      c_st_fill, c_st_heat:  mode_of = 2'b01;
      c_st_wash, c_st_rinse: mode_of = 2'b10;
      c_st_spin:             mode_of = 2'b11;
      default:               mode_of = 2'b00;
    endcase
  endfunction

  always_comb begin
    case (r_prev_state)
      c_st_fill:  w_limit_last = c_fill_last;
      c_st_heat:  w_limit_last = c_heat_last;
      c_st_wash:  w_limit_last = c_wash_last;
      c_st_rinse: w_limit_last = c_rinse_last;
      c_st_spin:  w_limit_last = c_spin_last;
      default:    w_limit_last = c_tout_last;
    endcase
  end

  always_comb begin
    w_tstate_nxt = r_tstate;
    w_prev_nxt   = r_prev_state;
    w_cnt_nxt    = r_cnt;
    w_mode_nxt   = r_mode;
    w_full_nxt   = 1'b0;
    w_temp_nxt   = 1'b0;
    w_comp_nxt   = 1'b0;
    w_tout_nxt   = 1'b0;

    // A controller state change restarts the phase and overrides any pulse.
    if (state != r_prev_state) begin
      w_prev_nxt   = state;
      w_cnt_nxt    = '0;
      w_mode_nxt   = mode_of(state);
      w_tstate_nxt = (state == c_st_idle || state == c_st_fault) ? T_IDLE : T_RUN;
    end else begin
      unique case (r_tstate)
        T_IDLE: begin
          w_cnt_nxt = '0;
        end
        T_RUN: begin
          if (r_cnt == w_limit_last) begin
            w_cnt_nxt = '0;
            case (r_prev_state)
              c_st_ready: begin
                w_tout_nxt   = 1'b1;
                w_tstate_nxt = T_HOLD;
              end
              c_st_fill: begin
                w_full_nxt   = 1'b1;
                w_tstate_nxt = T_DONE;
              end
              c_st_heat: begin
                w_temp_nxt   = 1'b1;
                w_tstate_nxt = T_DONE;
              end
              c_st_wash, c_st_rinse, c_st_spin: begin
                w_comp_nxt   = 1'b1;
                w_tstate_nxt = T_DONE;
              end
              default: begin
                w_tstate_nxt = T_IDLE;
              end
            endcase
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        T_DONE: begin
          // Watchdog: the controller should have moved on after the done pulse.
          if (r_cnt == c_tout_last) begin
            w_tout_nxt   = 1'b1;
            w_tstate_nxt = T_HOLD;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        T_HOLD: begin
          w_cnt_nxt = r_cnt;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tstate     <= T_IDLE;
      r_prev_state <= c_st_idle;
      r_cnt        <= '0;
      r_mode       <= 2'b00;
      r_full       <= 1'b0;
      r_temp       <= 1'b0;
      r_comp       <= 1'b0;
      r_tout       <= 1'b0;
    end else begin
      r_tstate     <= w_tstate_nxt;
      r_prev_state <= w_prev_nxt;
      r_cnt        <= w_cnt_nxt;
      r_mode       <= w_mode_nxt;
      r_full       <= w_full_nxt;
      r_temp       <= w_temp_nxt;
      r_comp       <= w_comp_nxt;
      r_tout       <= w_tout_nxt;
    end
  end

  assign sig_Full        = r_full;
  assign sig_Temperature = r_temp;
  assign sig_Completed   = r_comp;
  assign sig_Time_Out    = r_tout;
  assign mode            = r_mode;

endmodule
`default_nettype wire
